seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Scan controller for an 8-digit multiplexed 7-segment display driven through two cascaded 74HC595s. Each dwell period it selects one digit, builds a 16-bit frame and hands it to the 595 serializer with a start/done handshake. The serializer shifts MSB first and latches with ST_CP. Sits between the display-value registers and the serializer.

Parameters:
SCAN_DWELL, 50000, cycles each digit stays lit after its frame is latched (min 2)
DONE_TIMEOUT, 256, max cycles to wait for Shift_Done before flagging an error (min 2)
SEG_ACTIVE_LOW, 1, 1 = segment bits inverted (common anode); 0 = active-high

Ports:
Clk  in  1  system clock
Reset  in  1  reset; one clock, reset is asynchronous and active-high
Enable  in  1  scanning runs while high
Disp_Data  in  32  8 hex nibbles; digit i = Disp_Data[4i+3:4i]
Disp_En  in  8  per-digit enable
Disp_Dp  in  8  per-digit decimal point
Shift_Data  out  16  frame to serializer: {SEG[7:0]=dp,g,f,e,d,c,b,a ; SEL[7:0] one-hot active-high}
Shift_Start  out  1  one-cycle pulse; Shift_Data is valid on and after this cycle until Shift_Done
Shift_Done  in  1  one-cycle pulse from serializer after ST_CP latch
Digit_Idx  out  3  index of the digit currently shown
Frame_Tick  out  1  one-cycle pulse when the scan wraps past digit 7
Err  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset values: Shift_Data = blank (SEG all off per SEG_ACTIVE_LOW, SEL = 0), i.e. 16'hFF00 when SEG_ACTIVE_LOW = 1. Shift_Start = 0, Digit_Idx = 0, Frame_Tick = 0, Err = 0. State = IDLE, counters = 0, snapshot = 0.
- Reset mid-transaction aborts immediately. No Shift_Start is issued until the FSM leaves IDLE again.
- Segment decode (a..g, active-high before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71. Bit 7 = Disp_Dp[i]. Invert all 8 SEG bits if SEG_ACTIVE_LOW.
- Snapshot: Disp_Data, Disp_En and Disp_Dp are registered together on IDLE->SELECT and on every scan wrap. Changes mid-frame are not visible until the next wrap (tear-free).
- FSM:
  - IDLE: wait for Enable = 1; take snapshot, idx = 0 -> SELECT.
  - SELECT (1 cycle): find the first enabled digit at index >= idx in the snapshot.
    - Found: idx = that digit; register Shift_Data = {decode, one-hot(idx)}; Digit_Idx = idx -> START.
    - None found at >= idx, but the snapshot enable mask is nonzero: pulse Frame_Tick, take a new snapshot, idx = 0, re-search next cycle.
    - Snapshot enable mask = 0: register the blank frame; Digit_Idx = 0 -> START.
  - START (1 cycle): Shift_Start = 1; clear timeout counter -> WAIT.
  - WAIT: Shift_Done -> DWELL (dwell counter = 0). Timeout counter reaches DONE_TIMEOUT-1 without Done -> pulse Err -> IDLE. Done in the same cycle as the timeout terminal count: Done wins, no Err.
  - DWELL: count 0..SCAN_DWELL-1. At terminal count:
    - idx = idx+1 (3-bit). If that wraps 7->0: pulse Frame_Tick and take a new snapshot.
    - Enable = 0 -> IDLE, otherwise -> SELECT.
- Enable low during START, WAIT or DWELL lets the current transaction and dwell finish. Shift_Data holds its last frame in IDLE.
- Shift_Done outside WAIT is ignored.
- Latency: Enable rise to first Shift_Start = 3 cycles (IDLE, SELECT, START). Steady-state period per digit = 2 + handshake cycles + SCAN_DWELL.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: within the snapshot, enabled digits from index 7 downward whose nibble is 0 are sent with SEG off (dp still honoured), up to the first nonzero enabled digit. Digit 0 is never blanked. Digits are still scanned and dwelled.
- Undefined: all enabled digits are decoded normally.

Test Plan:
- SCAN_DWELL=4, Enable=1, Disp_En=8'h01, Disp_Data=32'h5, Dp=0 -> Shift_Data=16'h9201 on first Shift_Start 3 cycles after Enable; Frame_Tick on every scan wrap.
- Disp_En=8'h81, Data=32'hA000_0003 -> frames alternate 16'hB001 (digit0 "3") and 16'h8880 (digit7 "A"); digits 1-6 skipped without dwell.
- Serializer never returns Shift_Done -> Err pulses exactly DONE_TIMEOUT cycles after START; FSM in IDLE; restarts from digit 0 on the next Enable.
- Disp_Data changed during the scan of digit 3 -> new value appears only after the next Frame_Tick.
- Disp_En=0 -> blank 16'hFF00 frame shifted once per dwell; Digit_Idx=0.
- Reset asserted in WAIT -> all outputs at reset values asynchronously; Shift_Done then ignored. With LEADING_ZERO_BLANK_EN defined, Data=32'h0000_0120 and En=8'hFF -> digits 7..3 blank (SEG=8'hFF), digit 0 shows "0".

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - frame handshake between the scan controller and the 74HC595 serializer
interface seg_scan_ctrl_if;
  logic [15:0] Shift_Data;
  logic        Shift_Start;
  logic        Shift_Done;

  modport master (output Shift_Data, output Shift_Start, input Shift_Done);
  modport slave  (input Shift_Data, input Shift_Start, output Shift_Done);
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit multiplexed 7-segment scan controller feeding a 595 serializer
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int SCAN_DWELL     = 50000,
  parameter int DONE_TIMEOUT   = 256,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic [31:0]            Disp_Data,
  input  logic [7:0]             Disp_En,
  input  logic [7:0]             Disp_Dp,
  seg_scan_ctrl_if.master        shift_if,
  output logic [2:0]             Digit_Idx,
  output logic                   Frame_Tick,
  output logic                   Err
);

  localparam int DW_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DWELL - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [7:0]  BLANK_SEG   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [15:0] BLANK_FRAME = {BLANK_SEG, 8'h00};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_WAIT,
    ST_DWELL
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        digit_idx_q, digit_idx_d;
  logic [15:0]       shift_data_q, shift_data_d;
  logic [31:0]       snap_data_q, snap_data_d;
  logic [7:0]        snap_en_q, snap_en_d;
  logic [7:0]        snap_dp_q, snap_dp_d;
  logic [TO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;

  logic              found;
  logic [2:0]        found_idx;
  logic [7:0]        lz_blank;
  logic [15:0]       found_frame;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Disabled digits are transparent: they neither blank nor end the zero run.
  always_comb begin
    logic leading;
    lz_blank = '0;
    leading  = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (snap_en_q[i] && leading) begin
        if (snap_data_q[4*i +: 4] == 4'h0) lz_blank[i] = 1'b1;
        else                               leading     = 1'b0;
      end
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Lowest enabled digit at or above the current index wins.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (snap_en_q[i] && (3'(i) >= idx_q)) begin
        found     = 1'b1;
        found_idx = 3'(i);
      end
    end
  end

  always_comb begin
    logic [6:0] seg_raw;
    logic [7:0] seg;
    seg_raw = lz_blank[found_idx] ? 7'h00 : seg_decode(snap_data_q[{found_idx, 2'b00} +: 4]);
    seg     = {snap_dp_q[found_idx], seg_raw};
    if (SEG_ACTIVE_LOW) seg = ~seg;
    found_frame = {seg, 8'h01 << found_idx};
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    digit_idx_d  = digit_idx_q;
    shift_data_d = shift_data_q;
    snap_data_d  = snap_data_q;
    snap_en_d    = snap_en_q;
    snap_dp_d    = snap_dp_q;
    tmo_cnt_d    = tmo_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    Frame_Tick   = 1'b0;
    Err          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          snap_data_d = Disp_Data;
          snap_en_d   = Disp_En;
          snap_dp_d   = Disp_Dp;
          idx_d       = '0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (found) begin
          idx_d        = found_idx;
          digit_idx_d  = found_idx;
          shift_data_d = found_frame;
          state_d      = ST_START;
        end else if (snap_en_q != 8'h00) begin
          Frame_Tick  = 1'b1;
          snap_data_d = Disp_Data;
          snap_en_d   = Disp_En;
          snap_dp_d   = Disp_Dp;
          idx_d       = '0;
        end else begin
          // idx keeps advancing so the wrap still refreshes the snapshot.
          shift_data_d = BLANK_FRAME;
          digit_idx_d  = '0;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (shift_if.Shift_Done) begin
          dwell_cnt_d = '0;
          state_d     = ST_DWELL;
        end else if (tmo_cnt_q == TO_LAST) begin
          Err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_DWELL: begin
        if (dwell_cnt_q == DW_LAST) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            Frame_Tick  = 1'b1;
            snap_data_d = Disp_Data;
            snap_en_d   = Disp_En;
            snap_dp_d   = Disp_Dp;
          end
          state_d = Enable ? ST_SELECT : ST_IDLE;
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      digit_idx_q  <= '0;
      shift_data_q <= BLANK_FRAME;
      snap_data_q  <= '0;
      snap_en_q    <= '0;
      snap_dp_q    <= '0;
      tmo_cnt_q    <= '0;
      dwell_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      digit_idx_q  <= digit_idx_d;
      shift_data_q <= shift_data_d;
      snap_data_q  <= snap_data_d;
      snap_en_q    <= snap_en_d;
      snap_dp_q    <= snap_dp_d;
      tmo_cnt_q    <= tmo_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
    end
  end

  assign shift_if.Shift_Data  = shift_data_q;
  assign shift_if.Shift_Start = (state_q == ST_START);
  assign Digit_Idx            = digit_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed vector bench for seg_scan_ctrl with a serializer responder
module tb_seg_scan_ctrl;
  localparam int DWELL = 4;
  localparam int TMO   = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [31:0] Disp_Data;
  logic [7:0]  Disp_En;
  logic [7:0]  Disp_Dp;
  logic [2:0]  Digit_Idx;
  logic        Frame_Tick;
  logic        Err;
  logic        done_auto = 1'b0;
  logic        done_manual = 1'b0;
  bit          ser_en = 1'b1;

  int errors = 0;
  int checks = 0;
  int st_cnt = 0;
  int ft_cnt = 0;
  int err_cnt = 0;

  seg_scan_ctrl_if sif ();
  assign sif.Shift_Done = done_auto | done_manual;

  seg_scan_ctrl #(.SCAN_DWELL(DWELL), .DONE_TIMEOUT(TMO), .SEG_ACTIVE_LOW(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Disp_Data(Disp_Data),
    .Disp_En(Disp_En), .Disp_Dp(Disp_Dp), .shift_if(sif),
    .Digit_Idx(Digit_Idx), .Frame_Tick(Frame_Tick), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  en;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [15:0] f0;
    logic [2:0]  i0;
    logic [15:0] f1;
    logic [2:0]  i1;
    int          ticks;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_start(output logic [15:0] f, output logic [2:0] di, output bit ok);
    ok = 1'b0;
    f  = '0;
    di = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (sif.Shift_Start) begin
        f  = sif.Shift_Data;
        di = Digit_Idx;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    Enable = 1'b0;
    Reset  = 1'b1;
    repeat (2) @(negedge Clk);
    Reset  = 1'b0;
    @(negedge Clk);
  endtask

  // Serializer responder: Done two cycles after each Start it accepts.
  initial begin
    forever begin
      @(negedge Clk);
      if (sif.Shift_Start && ser_en) begin
        repeat (2) @(negedge Clk);
        done_auto = 1'b1;
        @(negedge Clk);
        done_auto = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (sif.Shift_Start) st_cnt++;
      if (Frame_Tick) ft_cnt++;
      if (Err) err_cnt++;
    end
  end

  initial begin
    vec_t        vecs[5];
    logic [15:0] f;
    logic [2:0]  di;
    bit          ok;
    int          t0, s0, e0, k;

    vecs[0] = '{8'h01, 32'h0000_0005, 8'h00, 16'h9201, 3'd0, 16'h9201, 3'd0, 1};
    vecs[1] = '{8'h81, 32'hA000_0003, 8'h00, 16'hB001, 3'd0, 16'h8880, 3'd7, 0};
    vecs[2] = '{8'h00, 32'h1234_5678, 8'h00, 16'hFF00, 3'd0, 16'hFF00, 3'd0, 0};
    vecs[3] = '{8'h0C, 32'h0000_F900, 8'h08, 16'h9004, 3'd2, 16'h0E08, 3'd3, 0};
    vecs[4] = '{8'h02, 32'h0000_00B0, 8'h02, 16'h0302, 3'd1, 16'h0302, 3'd1, 1};

    Reset = 1'b1; Enable = 1'b0; Disp_Data = '0; Disp_En = '0; Disp_Dp = '0;
    #3;
    chk("rst_shift_data", sif.Shift_Data, 16'hFF00);
    chk("rst_shift_start", sif.Shift_Start, 1'b0);
    chk("rst_digit_idx", Digit_Idx, 3'd0);
    chk("rst_frame_tick", Frame_Tick, 1'b0);
    chk("rst_err", Err, 1'b0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      ser_en = 1'b1;
      Disp_En = vecs[v].en; Disp_Data = vecs[v].data; Disp_Dp = vecs[v].dp;
      Enable = 1'b1;
      @(negedge Clk);
      chk($sformatf("v%0d_lat_select", v), sif.Shift_Start, 1'b0);
      @(negedge Clk);
      chk($sformatf("v%0d_lat_start", v), sif.Shift_Start, 1'b1);
      chk($sformatf("v%0d_frame0", v), sif.Shift_Data, vecs[v].f0);
      chk($sformatf("v%0d_idx0", v), Digit_Idx, vecs[v].i0);
      t0 = ft_cnt;
      wait_start(f, di, ok);
      chk($sformatf("v%0d_start1_seen", v), ok, 1'b1);
      chk($sformatf("v%0d_frame1", v), f, vecs[v].f1);
      chk($sformatf("v%0d_idx1", v), di, vecs[v].i1);
      chk($sformatf("v%0d_ticks", v), ft_cnt - t0, vecs[v].ticks);
    end

    // Handshake timeout on digit 7, then restart from digit 0.
    do_reset();
    Disp_En = 8'h81; Disp_Data = 32'hA000_0003; Disp_Dp = 8'h00; ser_en = 1'b1;
    Enable = 1'b1;
    wait_start(f, di, ok);
    chk("to_first_frame", f, 16'hB001);
    @(negedge Clk);
    ser_en = 1'b0;
    wait_start(f, di, ok);
    chk("to_second_frame", f, 16'h8880);
    Enable = 1'b0;
    e0 = err_cnt;
    k = 0;
    for (int c = 1; c <= TMO + 5; c++) begin
      @(negedge Clk);
      if (Err) begin k = c; break; end
    end
    chk("to_err_latency", k, TMO);
    @(negedge Clk);
    chk("to_err_single", err_cnt - e0, 1);
    s0 = st_cnt;
    repeat (12) @(negedge Clk);
    chk("to_idle_no_start", st_cnt - s0, 0);
    ser_en = 1'b1;
    Enable = 1'b1;
    repeat (2) @(negedge Clk);
    chk("to_restart_start", sif.Shift_Start, 1'b1);
    chk("to_restart_frame", sif.Shift_Data, 16'hB001);
    chk("to_restart_idx", Digit_Idx, 3'd0);

    // Data changed mid-frame stays invisible until the wrap.
    do_reset();
    Disp_En = 8'h0F; Disp_Data = 32'h0000_1234; Disp_Dp = 8'h00; ser_en = 1'b1;
    Enable = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 4; n++) begin
      wait_start(f, di, ok);
      if (ok && di == 3'd1) break;
    end
    chk("tear_reach_digit1", {ok, di}, {1'b1, 3'd1});
    Disp_Data = 32'h0000_5678;
    wait_start(f, di, ok);
    chk("tear_digit2_old", f, 16'hA404);
    wait_start(f, di, ok);
    chk("tear_digit3_old", f, 16'hF908);
    t0 = ft_cnt;
    wait_start(f, di, ok);
    chk("tear_digit0_new", f, 16'h8001);
    chk("tear_wrap_tick", ft_cnt - t0, 1);

    // Asynchronous reset while waiting for Done.
    do_reset();
    Disp_En = 8'h02; Disp_Data = 32'h0000_0050; Disp_Dp = 8'h00; ser_en = 1'b0;
    Enable = 1'b1;
    wait_start(f, di, ok);
    chk("arst_pre_frame", f, 16'h9202);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("arst_shift_data", sif.Shift_Data, 16'hFF00);
    chk("arst_digit_idx", Digit_Idx, 3'd0);
    chk("arst_shift_start", sif.Shift_Start, 1'b0);
    @(negedge Clk);
    Enable = 1'b0;
    Reset = 1'b0;
    s0 = st_cnt; e0 = err_cnt;
    done_manual = 1'b1;
    @(negedge Clk);
    done_manual = 1'b0;
    repeat (20) @(negedge Clk);
    chk("arst_no_start", st_cnt - s0, 0);
    chk("arst_no_err", err_cnt - e0, 0);

`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic [15:0] lz_exp[8];
      lz_exp = '{16'hC001, 16'hA402, 16'hF904, 16'hFF08, 16'hFF10, 16'hFF20, 16'hFF40, 16'hFF80};
      do_reset();
      Disp_En = 8'hFF; Disp_Data = 32'h0000_0120; Disp_Dp = 8'h00; ser_en = 1'b1;
      Enable = 1'b1;
      for (int d = 0; d < 8; d++) begin
        wait_start(f, di, ok);
        chk($sformatf("lzb_digit%0d", d), {ok, di, f}, {1'b1, 3'(d), lz_exp[d]});
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
